bram_ecc_scrubber: RTL and testbench

Port controller for one ECC-enabled 40K block RAM port in TDP mode (512 × 32 data, ECC on, no output register). It shares that port between a user requester and a background scrubber. The scrubber walks every address, corrects single-bit errors by writing the corrected word back, and records double-bit errors. It sits between user logic and the port-B pins of the RAM primitive; port A stays directly with the user.

---
 rtl/bram_ecc_scrubber_pkg.sv | 21 ++
 rtl/bram_ecc_scrubber_if.sv | 33 +++
 rtl/bram_ecc_scrubber_scrub_timer.sv | 63 ++++++
 rtl/bram_ecc_scrubber.sv | 211 +++++++++++++++++++++
 tb/tb_bram_ecc_scrubber.sv | 344 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_ecc_scrubber_pkg.sv
// Shared definitions for the ECC block-RAM port controller and scrubber.
// Contents:
//   CNT_W      - width of the saturating error counters
//   ST_*       - scrub FSM state encodings (also visible on dbg_state)
//   sat_inc()  - saturating increment for the statistics counters
package bram_ecc_scrubber_pkg;

  localparam int CNT_W = 16;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;  // waiting for a pending scrub step
  localparam logic [1:0] ST_SC_RD  = 2'd1;  // scrub read in flight
  localparam logic [1:0] ST_SC_CHK = 2'd2;  // evaluate sampled ECC flags
  localparam logic [1:0] ST_SC_WB  = 2'd3;  // write corrected word back

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/bram_ecc_scrubber_if.sv
// User-side request/response bus of the ECC block-RAM port controller.
// Signals:
//   usr_req/usr_we/usr_addr/usr_wdata - request from the user (master drives)
//   usr_gnt                           - request accepted this cycle
//   usr_rvalid/usr_rdata/usr_err1/2   - read response with ECC flags
// Handshake: a request is accepted in a cycle where usr_req && usr_gnt.
// The master holds req/we/addr/wdata stable until accepted. A read returns
// exactly one cycle after acceptance with usr_rvalid high for one cycle;
// the response has no backpressure. Writes return nothing.
interface bram_ecc_scrubber_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              usr_req;
  logic              usr_we;
  logic [ADDR_W-1:0] usr_addr;
  logic [DATA_W-1:0] usr_wdata;
  logic              usr_gnt;
  logic              usr_rvalid;
  logic [DATA_W-1:0] usr_rdata;
  logic              usr_err1;
  logic              usr_err2;

  modport master (
    output usr_req, usr_we, usr_addr, usr_wdata,
    input  usr_gnt, usr_rvalid, usr_rdata, usr_err1, usr_err2
  );

  modport slave (
    input  usr_req, usr_we, usr_addr, usr_wdata,
    output usr_gnt, usr_rvalid, usr_rdata, usr_err1, usr_err2
  );
endinterface

// File: rtl/bram_ecc_scrubber_scrub_timer.sv
// Scrub pacing timer and starvation wait counter.
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   en_i        - scrubbing enabled; when low the interval timer holds at reload
//   blocked_i   - scrubber has an action but the user kept the port this cycle
//   issue_i     - scrubber drives the port this cycle
//   tick_o      - interval elapsed this cycle (sets the pending step)
//   starved_o   - scrubber has waited long enough to preempt the user
module bram_ecc_scrubber_scrub_timer #(
  parameter int INTERVAL     = 1024,
  parameter int STARVE_LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic blocked_i,
  input  logic issue_i,
  output logic tick_o,
  output logic starved_o
);

  localparam int TW = (INTERVAL > 1) ? $clog2(INTERVAL) : 1;
  localparam int WW = $clog2(STARVE_LIMIT + 1);
  localparam logic [TW-1:0] RELOAD = TW'(INTERVAL - 1);
  localparam logic [WW-1:0] LIMIT  = WW'(STARVE_LIMIT);

  logic [TW-1:0] timer_q, timer_d;
  logic [WW-1:0] wait_q, wait_d;

  assign tick_o    = en_i && (timer_q == '0);
  assign starved_o = (wait_q == LIMIT);

  always_comb begin
    timer_d = timer_q;
    if (!en_i || (timer_q == '0)) begin
      timer_d = RELOAD;
    end else begin
      timer_d = timer_q - TW'(1);
    end
  end

  // Wait counter saturates at the limit so preemption stays asserted
  // until the scrubber actually gets the port.
  always_comb begin
    wait_d = wait_q;
    if (issue_i) begin
      wait_d = '0;
    end else if (blocked_i && (wait_q != LIMIT)) begin
      wait_d = wait_q + WW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_q <= RELOAD;
      wait_q  <= '0;
    end else begin
      timer_q <= timer_d;
      wait_q  <= wait_d;
    end
  end

endmodule

// File: rtl/bram_ecc_scrubber.sv
// Port controller for one ECC block-RAM port shared between a user requester
// and a background scrubber that corrects single-bit errors by writeback and
// records double-bit errors.
// Ports:
//   clk, rst              - clock, asynchronous active-high reset
//   usr                   - user request/response bus (slave side)
//   scrub_en              - enable background scrubbing
//   clr_stats             - synchronous clear of statistics outputs
//   ram_en/we/addr/wdata  - RAM port controls (address is the word address)
//   ram_rdata, ram_ecc_*  - RAM read data and ECC flags (1-cycle latency)
//   corr_cnt, uncorr_cnt  - saturating corrected/uncorrectable counters
//   uncorr_flag/addr      - sticky double-error flag and first failing address
//   pass_done             - pulse when the scrub address wraps to 0
//   dbg_state             - current scrub FSM state
module bram_ecc_scrubber
  import bram_ecc_scrubber_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 32,
  parameter int INTERVAL     = 1024,
  parameter int STARVE_LIMIT = 64
) (
  input  logic              clk,
  input  logic              rst,
  bram_ecc_scrubber_if.slave usr,
  input  logic              scrub_en,
  input  logic              clr_stats,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ecc_1b,
  input  logic              ram_ecc_2b,
  output logic [CNT_W-1:0]  corr_cnt,
  output logic [CNT_W-1:0]  uncorr_cnt,
  output logic              uncorr_flag,
  output logic [ADDR_W-1:0] uncorr_addr,
  output logic              pass_done,
  output state_t            dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] scrub_addr_q, scrub_addr_d;
  logic              pending_q, pending_d;
  logic              kill_q, kill_d;
  logic [DATA_W-1:0] smp_data_q;
  logic              smp_e1_q, smp_e2_q;
  logic              rvalid_q;
  logic [CNT_W-1:0]  corr_q, corr_d;
  logic [CNT_W-1:0]  uncorr_q, uncorr_d;
  logic              uflag_q, uflag_d;
  logic [ADDR_W-1:0] uaddr_q, uaddr_d;
  logic              pass_q, pass_d;

  logic tick, starved;
  logic want_rd, want_wb, want, own, gnt, usr_hit;
  logic advance;

  // Scrubber has something to put on the port: a new read (only while
  // enabled) or a writeback that has not been superseded by a user write.
  assign want_rd = (state_q == ST_IDLE) && pending_q && scrub_en;
  assign want_wb = (state_q == ST_SC_WB) && !kill_q;
  assign want    = want_rd || want_wb;
  assign own     = want && (!usr.usr_req || starved);
  assign gnt     = usr.usr_req && !own;
  assign usr_hit = gnt && usr.usr_we && (usr.usr_addr == scrub_addr_q);

  bram_ecc_scrubber_scrub_timer #(
    .INTERVAL    (INTERVAL),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .en_i     (scrub_en),
    .blocked_i(want && !own),
    .issue_i  (own),
    .tick_o   (tick),
    .starved_o(starved)
  );

  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (own) begin
      ram_en    = 1'b1;
      ram_we    = want_wb;
      ram_addr  = scrub_addr_q;
      ram_wdata = want_wb ? smp_data_q : '0;
    end else if (gnt) begin
      ram_en    = 1'b1;
      ram_we    = usr.usr_we;
      ram_addr  = usr.usr_addr;
      ram_wdata = usr.usr_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    scrub_addr_d = scrub_addr_q;
    pending_d    = pending_q || tick;
    kill_d       = kill_q;
    corr_d       = corr_q;
    uncorr_d     = uncorr_q;
    uflag_d      = uflag_q;
    uaddr_d      = uaddr_q;
    pass_d       = 1'b0;
    advance      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (own) begin
          pending_d = tick;
          state_d   = ST_SC_RD;
        end
      end
      ST_SC_RD: begin
        kill_d  = 1'b0;
        state_d = ST_SC_CHK;
      end
      ST_SC_CHK: begin
        if (smp_e2_q) begin
          uncorr_d = sat_inc(uncorr_q);
          uflag_d  = 1'b1;
          if (!uflag_q) uaddr_d = scrub_addr_q;
          advance  = 1'b1;
        end else if (smp_e1_q) begin
          // smp_data_q already holds the RAM's corrected word and stays
          // untouched until the next scrub read, so it is the writeback data.
          corr_d  = sat_inc(corr_q);
          kill_d  = usr_hit;
          state_d = ST_SC_WB;
        end else begin
          advance = 1'b1;
        end
      end
      default: begin  // ST_SC_WB
        if (kill_q || own) begin
          advance = 1'b1;
        end else begin
          kill_d = usr_hit;
        end
      end
    endcase

    if (advance) begin
      scrub_addr_d = scrub_addr_q + ADDR_W'(1);
      pass_d       = (scrub_addr_q == {ADDR_W{1'b1}});
      state_d      = ST_IDLE;
    end

    if (clr_stats) begin
      corr_d   = '0;
      uncorr_d = '0;
      uflag_d  = 1'b0;
      uaddr_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      scrub_addr_q <= '0;
      pending_q    <= 1'b0;
      kill_q       <= 1'b0;
      smp_data_q   <= '0;
      smp_e1_q     <= 1'b0;
      smp_e2_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      corr_q       <= '0;
      uncorr_q     <= '0;
      uflag_q      <= 1'b0;
      uaddr_q      <= '0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scrub_addr_q <= scrub_addr_d;
      pending_q    <= pending_d;
      kill_q       <= kill_d;
      rvalid_q     <= gnt && !usr.usr_we;
      corr_q       <= corr_d;
      uncorr_q     <= uncorr_d;
      uflag_q      <= uflag_d;
      uaddr_q      <= uaddr_d;
      pass_q       <= pass_d;
      // RAM output is valid during SC_RD; capture it here because a user
      // access granted in SC_RD will change the RAM output in SC_CHK.
      if (state_q == ST_SC_RD) begin
        smp_data_q <= ram_rdata;
        smp_e1_q   <= ram_ecc_1b;
        smp_e2_q   <= ram_ecc_2b;
      end
    end
  end

  assign usr.usr_gnt    = gnt;
  assign usr.usr_rvalid = rvalid_q;
  assign usr.usr_rdata  = rvalid_q ? ram_rdata : '0;
  assign usr.usr_err1   = rvalid_q && ram_ecc_1b;
  assign usr.usr_err2   = rvalid_q && ram_ecc_2b;

  assign corr_cnt    = corr_q;
  assign uncorr_cnt  = uncorr_q;
  assign uncorr_flag = uflag_q;
  assign uncorr_addr = uaddr_q;
  assign pass_done   = pass_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_bram_ecc_scrubber.sv
// Testbench for bram_ecc_scrubber: behavioural ECC RAM model, user driver
// task, scoreboard queues for user read responses and scrubber port accesses,
// directed phases for reset, user traffic, 1-bit/2-bit errors, starvation,
// writeback race and address wrap.
module tb_bram_ecc_scrubber;
  import bram_ecc_scrubber_pkg::*;

  localparam int ADDR_W       = 9;
  localparam int DATA_W       = 32;
  localparam int INTERVAL     = 16;
  localparam int STARVE_LIMIT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- DUT ----------------
  bram_ecc_scrubber_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) usr();

  logic              scrub_en, clr_stats;
  logic              ram_en, ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              ram_ecc_1b, ram_ecc_2b;
  logic [CNT_W-1:0]  corr_cnt, uncorr_cnt;
  logic              uncorr_flag, pass_done;
  logic [ADDR_W-1:0] uncorr_addr;
  state_t            dbg_state;

  bram_ecc_scrubber #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .INTERVAL(INTERVAL), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .usr(usr),
    .scrub_en(scrub_en), .clr_stats(clr_stats),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ecc_1b(ram_ecc_1b), .ram_ecc_2b(ram_ecc_2b),
    .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt), .uncorr_flag(uncorr_flag),
    .uncorr_addr(uncorr_addr), .pass_done(pass_done), .dbg_state(dbg_state)
  );

  // ---------------- ECC RAM model ----------------
  // flip[] marks corrupted stored bits: one bit -> corrected data + 1b flag,
  // two or more -> raw corrupted data + 2b flag. Any write cleans the word.
  logic [DATA_W-1:0] mem  [0:511];
  logic [DATA_W-1:0] flip [0:511];
  logic [ADDR_W-1:0] inj_addr;
  logic [DATA_W-1:0] inj_mask;
  logic              inj_tog = 1'b0;
  logic              inj_seen;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 512; i++) begin
        mem[i]  <= '0;
        flip[i] <= '0;
      end
      ram_rdata  <= '0;
      ram_ecc_1b <= 1'b0;
      ram_ecc_2b <= 1'b0;
      inj_seen   <= inj_tog;
    end else begin
      if (ram_en) begin
        if (ram_we) begin
          mem[ram_addr]  <= ram_wdata;
          flip[ram_addr] <= '0;
        end else begin
          case ($countones(flip[ram_addr]))
            0: begin ram_rdata <= mem[ram_addr]; ram_ecc_1b <= 1'b0; ram_ecc_2b <= 1'b0; end
            1: begin ram_rdata <= mem[ram_addr]; ram_ecc_1b <= 1'b1; ram_ecc_2b <= 1'b0; end
            default: begin
              ram_rdata  <= mem[ram_addr] ^ flip[ram_addr];
              ram_ecc_1b <= 1'b0;
              ram_ecc_2b <= 1'b1;
            end
          endcase
        end
      end
      if (inj_tog != inj_seen) begin
        flip[inj_addr] <= inj_mask;
        inj_seen       <= inj_tog;
      end
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [15:0] cyc;
    logic [33:0] v;      // {err2, err1, rdata}
  } rd_exp_t;

  typedef struct packed {
    logic        chk_cyc;
    logic [15:0] cyc;
    logic        we;
    logic [8:0]  addr;
    logic [31:0] data;
  } sc_exp_t;

  rd_exp_t exp_rd_q[$];
  sc_exp_t exp_sc_q[$];

  int n_chk = 0;
  int n_ok  = 0;
  int n_pass_done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_ok++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_sc(input logic chk_c, input int c, input logic we,
                         input logic [8:0] a, input logic [31:0] d);
    exp_sc_q.push_back('{chk_cyc: chk_c, cyc: 16'(c), we: we, addr: a, data: d});
  endtask

  // Read-response monitor
  rd_exp_t rd_e;
  always @(negedge clk) begin
    if (!rst && usr.usr_rvalid) begin
      if (exp_rd_q.size() == 0) begin
        check("rd_unexpected", {30'd0, usr.usr_err2, usr.usr_err1, usr.usr_rdata}, 64'h1_0000_0000_0000);
      end else begin
        rd_e = exp_rd_q.pop_front();
        check("rd_cycle", 64'(cyc), 64'(rd_e.cyc));
        check("rd_data", {30'd0, usr.usr_err2, usr.usr_err1, usr.usr_rdata}, {30'd0, rd_e.v});
      end
    end
  end

  // Scrubber port-access monitor: port used while the user is not granted
  sc_exp_t sc_e;
  always @(negedge clk) begin
    if (!rst && ram_en && !usr.usr_gnt) begin
      if (exp_sc_q.size() == 0) begin
        check("sc_unexpected", {ram_we, ram_addr, ram_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        sc_e = exp_sc_q.pop_front();
        check("sc_access", {ram_we, ram_addr, ram_we ? ram_wdata : 32'h0},
              {sc_e.we, sc_e.addr, sc_e.data});
        if (sc_e.chk_cyc) check("sc_cycle", 64'(cyc), 64'(sc_e.cyc));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && pass_done) n_pass_done++;
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after a rising edge; holds the request until granted.
  task automatic usr_op(input logic we, input logic [8:0] a, input logic [31:0] d,
                        input logic [33:0] exp_v);
    int  n;
    logic done;
    n = 0;
    done = 1'b0;
    usr.usr_req   = 1'b1;
    usr.usr_we    = we;
    usr.usr_addr  = a;
    usr.usr_wdata = d;
    while (!done) begin
      @(negedge clk);
      if (usr.usr_gnt) begin
        done = 1'b1;
        if (!we) exp_rd_q.push_back('{cyc: 16'(cyc + 1), v: exp_v});
      end else if (++n > 100) begin
        check("usr_gnt_timeout", 64'(n), 64'd0);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    usr.usr_req = 1'b0;
    usr.usr_we  = 1'b0;
  endtask

  task automatic inject(input logic [8:0] a, input logic [31:0] m);
    inj_addr = a;
    inj_mask = m;
    inj_tog  = ~inj_tog;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sc_drain(input int budget);
    int n;
    n = 0;
    while (exp_sc_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("sc_drain", 64'(exp_sc_q.size()), 64'd0);
  endtask

  task automatic wait_rd_drain();
    repeat (3) @(posedge clk);
    #1;
    check("rd_drain", 64'(exp_rd_q.size()), 64'd0);
  endtask

  // ---------------- stimulus ----------------
  int e_cyc, n_drop, drop_cyc, pd0;

  initial begin
    usr.usr_req = 1'b0; usr.usr_we = 1'b0; usr.usr_addr = '0; usr.usr_wdata = '0;
    scrub_en = 1'b1; clr_stats = 1'b0; inj_addr = '0; inj_mask = '0;

    // Reset and idle scrub
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_usr", {usr.usr_gnt, usr.usr_rvalid, usr.usr_err1, usr.usr_err2, usr.usr_rdata}, 64'd0);
    check("rst_ram", {ram_en, ram_we, ram_addr, ram_wdata}, 64'd0);
    check("rst_stats", {corr_cnt, uncorr_cnt, uncorr_flag, uncorr_addr, pass_done}, 64'd0);
    check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
    push_sc(1'b1, 16, 1'b0, 9'd0, 32'h0);
    push_sc(1'b1, 32, 1'b0, 9'd1, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    wait_cyc(36);
    scrub_en = 1'b0;
    wait_sc_drain(50);
    check("idle_counts", {corr_cnt, uncorr_cnt, uncorr_flag}, 64'd0);

    // User write and read
    usr_op(1'b1, 9'd5, 32'h1234_5678, 34'h0);
    usr_op(1'b0, 9'd5, 32'h0, {2'b00, 32'h1234_5678});
    usr_op(1'b1, 9'd2, 32'h1234_5678, 34'h0);
    wait_rd_drain();

    // Single-bit error at the next scrub address (2): corrected writeback
    inject(9'd2, 32'h0000_0008);
    e_cyc = cyc;
    push_sc(1'b1, e_cyc + 16, 1'b0, 9'd2, 32'h0);
    push_sc(1'b1, e_cyc + 19, 1'b1, 9'd2, 32'h1234_5678);
    scrub_en = 1'b1;
    wait_cyc(e_cyc + 22);
    scrub_en = 1'b0;
    wait_sc_drain(50);
    check("sb_counts", {corr_cnt, uncorr_cnt}, {16'd1, 16'd0});
    usr_op(1'b0, 9'd2, 32'h0, {2'b00, 32'h1234_5678});
    wait_rd_drain();

    // Double-bit error at address 7: clean steps 3..6 first
    inject(9'd7, 32'h0000_0101);
    e_cyc = cyc;
    for (int k = 0; k < 5; k++) push_sc(1'b1, e_cyc + 16 * (k + 1), 1'b0, 9'(3 + k), 32'h0);
    scrub_en = 1'b1;
    wait_cyc(e_cyc + 86);
    scrub_en = 1'b0;
    wait_sc_drain(50);
    check("db_uncorr_cnt", 64'(uncorr_cnt), 64'd1);
    check("db_flag_addr", {uncorr_flag, uncorr_addr}, {1'b1, 9'd7});
    check("db_corr_cnt", 64'(corr_cnt), 64'd1);
    clr_stats = 1'b1;
    @(posedge clk);
    #1 clr_stats = 1'b0;
    @(negedge clk);
    check("clr_stats", {corr_cnt, uncorr_cnt, uncorr_flag, uncorr_addr}, 64'd0);
    @(posedge clk);
    #1;
    usr_op(1'b1, 9'd7, 32'h0, 34'h0);

    // Starvation: user reads continuously; scrubber preempts once
    e_cyc = cyc;
    n_drop = 0;
    drop_cyc = -1;
    push_sc(1'b1, e_cyc + 16 + STARVE_LIMIT, 1'b0, 9'd8, 32'h0);
    scrub_en = 1'b1;
    usr.usr_req = 1'b1; usr.usr_we = 1'b0; usr.usr_addr = 9'd5;
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      if (usr.usr_gnt) exp_rd_q.push_back('{cyc: 16'(cyc + 1), v: {2'b00, 32'h1234_5678}});
      else begin
        n_drop++;
        drop_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (cyc == e_cyc + 28) scrub_en = 1'b0;
    end
    usr.usr_req = 1'b0;
    check("starve_drops", 64'(n_drop), 64'd1);
    check("starve_cycle", 64'(drop_cyc), 64'(e_cyc + 16 + STARVE_LIMIT));
    wait_sc_drain(20);
    wait_rd_drain();

    // Writeback race at address 9: user write during SC_CHK kills writeback
    usr_op(1'b1, 9'd9, 32'h1111_1111, 34'h0);
    inject(9'd9, 32'h0000_0010);
    e_cyc = cyc;
    push_sc(1'b1, e_cyc + 16, 1'b0, 9'd9, 32'h0);
    scrub_en = 1'b1;
    wait_cyc(e_cyc + 18);
    check("race_in_chk", 64'(dbg_state), 64'(ST_SC_CHK));
    usr_op(1'b1, 9'd9, 32'hCAFE_F00D, 34'h0);
    wait_cyc(e_cyc + 22);
    scrub_en = 1'b0;
    wait_sc_drain(20);
    check("race_corr_cnt", 64'(corr_cnt), 64'd1);
    usr_op(1'b0, 9'd9, 32'h0, {2'b00, 32'hCAFE_F00D});
    wait_rd_drain();

    // Full pass: 512 consecutive clean steps starting at address 10
    pd0 = n_pass_done;
    for (int k = 0; k < 512; k++) push_sc(1'b0, 0, 1'b0, 9'((10 + k) % 512), 32'h0);
    scrub_en = 1'b1;
    wait_sc_drain(512 * INTERVAL + 100);
    scrub_en = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("pass_done_count", 64'(n_pass_done - pd0), 64'd1);
    check("wrap_counts", {corr_cnt, uncorr_cnt, uncorr_flag}, {16'd1, 16'd0, 1'b0});
    check("end_state", 64'(dbg_state), 64'(ST_IDLE));
    check("rd_q_empty", 64'(exp_rd_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
